// File: rtl/derank_engine.sv
// +--------------------------------------------------------------------------+
// | derank_engine: 8-slot lookup table scanned for a {handle, rank} match     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module derank_engine #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_slot,
  input  logic [7:0] wr_handle,
  input  logic [7:0] wr_rank,
  input  logic [7:0] wr_index,
  input  logic [7:0] wr_value,
  input  logic       clr,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_handle,
  input  logic [7:0] req_rank,
  input  logic       isMetadata,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resultBool,
  output logic [7:0] resultValue,
  output logic [7:0] resultContext
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic [DEPTH-1:0] r_valid;
  logic [7:0]       r_tbl_handle [DEPTH];
  logic [7:0]       r_tbl_rank   [DEPTH];
  logic [7:0]       r_tbl_index  [DEPTH];
  logic [7:0]       r_tbl_value  [DEPTH];

  logic [2:0] r_cnt;
  logic [7:0] r_cap_handle;
  logic [7:0] r_cap_rank;
  logic       r_bool;
  logic [7:0] r_value;
  logic [7:0] r_ctx;

  logic w_accept;
  logic w_oos;
  logic w_hit;
  logic w_last;

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_oos    = !isMetadata || (req_handle > 8'd7);
  assign w_hit    = r_valid[r_cnt] && (r_tbl_handle[r_cnt] == r_cap_handle)
                    && (r_tbl_rank[r_cnt] == r_cap_rank);
  assign w_last   = (r_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_next = w_oos ? S_DONE : S_SCAN;
      S_SCAN: if (w_hit || w_last) w_next = S_DONE;
      S_DONE: if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Table: clr beats a same-cycle write on the valid bit; data still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tbl_handle[i] <= '0;
        r_tbl_rank[i]   <= '0;
        r_tbl_index[i]  <= '0;
        r_tbl_value[i]  <= '0;
      end
    end else begin
      if (clr) begin
        r_valid <= '0;
      end else if (wr_en) begin
        r_valid[wr_slot] <= 1'b1;
      end
      if (wr_en) begin
        r_tbl_handle[wr_slot] <= wr_handle;
        r_tbl_rank[wr_slot]   <= wr_rank;
        r_tbl_index[wr_slot]  <= wr_index;
        r_tbl_value[wr_slot]  <= wr_value;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_cap_handle <= '0;
      r_cap_rank   <= '0;
      r_bool       <= 1'b0;
      r_value      <= '0;
      r_ctx        <= '0;
    end else begin
      if (w_accept) begin
        r_cap_handle <= req_handle;
        r_cap_rank   <= req_rank;
        r_cnt        <= '0;
        if (w_oos) begin
          r_bool  <= 1'b0;
          r_value <= req_rank;
          r_ctx   <= req_rank;
        end
      end else if (r_state == S_SCAN) begin
        if (w_hit) begin
          r_bool  <= 1'b1;
          r_value <= r_tbl_value[r_cnt];
          r_ctx   <= r_tbl_index[r_cnt];
        end else if (w_last) begin
          r_bool  <= 1'b0;
          r_value <= r_cap_rank;
          r_ctx   <= r_cap_rank;
        end else begin
          r_cnt <= r_cnt + 3'd1;
        end
      end
    end
  end

  // Ready is held low while reset is asserted, even though the FSM sits in IDLE.
  assign req_ready     = (r_state == S_IDLE) && rst_n;
  assign resp_valid    = (r_state == S_DONE);
  assign resultBool    = r_bool;
  assign resultValue   = r_value;
  assign resultContext = r_ctx;

endmodule

`default_nettype wire

// File: tb/tb_derank_engine.sv
// +--------------------------------------------------------------------------+
// | tb_derank_engine: directed vector bench for derank_engine                 |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_derank_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_slot;
  logic [7:0] wr_handle, wr_rank, wr_index, wr_value;
  logic       clr;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_handle, req_rank;
  logic       isMetadata;
  logic       resp_valid;
  logic       resp_ready;
  logic       resultBool;
  logic [7:0] resultValue, resultContext;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  derank_engine #(.DEPTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_slot       (wr_slot),
    .wr_handle     (wr_handle),
    .wr_rank       (wr_rank),
    .wr_index      (wr_index),
    .wr_value      (wr_value),
    .clr           (clr),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_handle    (req_handle),
    .req_rank      (req_rank),
    .isMetadata    (isMetadata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resultBool    (resultBool),
    .resultValue   (resultValue),
    .resultContext (resultContext)
  );

  typedef struct {
    logic [7:0] h;
    logic [7:0] r;
    logic       m;
    int         lat;
    logic       b;
    logic [7:0] v;
    logic [7:0] c;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_slot(input logic [2:0] s, input logic [7:0] h, r, idx, val, input logic with_clr);
    wr_en = 1'b1; wr_slot = s; wr_handle = h; wr_rank = r; wr_index = idx; wr_value = val;
    clr = with_clr;
    @(negedge clk);
    wr_en = 1'b0; clr = 1'b0;
  endtask

  // Called at a negedge; lat counts cycles after the accept cycle T.
  task automatic do_req(input logic [7:0] h, r, input logic m, input int clr_at,
                        output int lat, output logic b, output logic [7:0] v, c);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_handle = h; req_rank = r; isMetadata = m;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (lat < 30) begin
      clr = (lat == clr_at);
      if (resp_valid) break;
      @(negedge clk);
      lat++;
    end
    clr = 1'b0;
    b = resultBool; v = resultValue; c = resultContext;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_valid_drop", {31'd0, resp_valid}, 32'd0);
    chk("req_ready_back", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run_vec(input string name, input logic [7:0] h, r, input logic m, input int clr_at,
                         input int e_lat, input logic e_b, input logic [7:0] e_v, e_c);
    int lat; logic b; logic [7:0] v, c;
    do_req(h, r, m, clr_at, lat, b, v, c);
    chk({name, "_latency"}, lat, e_lat);
    chk({name, "_bool"}, {31'd0, b}, {31'd0, e_b});
    chk({name, "_value"}, {24'd0, v}, {24'd0, e_v});
    chk({name, "_context"}, {24'd0, c}, {24'd0, e_c});
    finish_resp();
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_slot = '0; wr_handle = '0; wr_rank = '0; wr_index = '0;
    wr_value = '0; clr = 1'b0; req_valid = 1'b0; req_handle = '0; req_rank = '0;
    isMetadata = 1'b0; resp_ready = 1'b0;

    vecs[0] = '{h: 8'd2,   r: 8'd5, m: 1'b1, lat: 5, b: 1'b1, v: 8'h44, c: 8'd9};
    vecs[1] = '{h: 8'd2,   r: 8'd6, m: 1'b1, lat: 9, b: 1'b0, v: 8'd6,  c: 8'd6};
    vecs[2] = '{h: 8'd8,   r: 8'd3, m: 1'b1, lat: 1, b: 1'b0, v: 8'd3,  c: 8'd3};
    vecs[3] = '{h: 8'd2,   r: 8'd5, m: 1'b0, lat: 1, b: 1'b0, v: 8'd5,  c: 8'd5};
    vecs[4] = '{h: 8'd1,   r: 8'd1, m: 1'b1, lat: 2, b: 1'b1, v: 8'h22, c: 8'h11};
    vecs[5] = '{h: 8'd7,   r: 8'd7, m: 1'b1, lat: 9, b: 1'b1, v: 8'h70, c: 8'h77};
    vecs[6] = '{h: 8'd255, r: 8'd9, m: 1'b1, lat: 1, b: 1'b0, v: 8'd9,  c: 8'd9};

    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_bool", {31'd0, resultBool}, 32'd0);
    chk("rst_value", {24'd0, resultValue}, 32'd0);
    chk("rst_context", {24'd0, resultContext}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);

    write_slot(3'd3, 8'd2, 8'd5, 8'd9,    8'h44, 1'b0);
    write_slot(3'd0, 8'd1, 8'd1, 8'h11,   8'h22, 1'b0);
    write_slot(3'd7, 8'd7, 8'd7, 8'h77,   8'h70, 1'b0);
    for (int i = 0; i < 7; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].h, vecs[i].r, vecs[i].m, -1,
              vecs[i].lat, vecs[i].b, vecs[i].v, vecs[i].c);
    end

    // Duplicate match: lowest slot wins, payload held while resp_ready low.
    begin
      int lat; logic b; logic [7:0] v, c;
      write_slot(3'd1, 8'd3, 8'd4, 8'h31, 8'hA1, 1'b0);
      write_slot(3'd6, 8'd3, 8'd4, 8'h36, 8'hA6, 1'b0);
      do_req(8'd3, 8'd4, 1'b1, -1, lat, b, v, c);
      chk("dup_latency", lat, 3);
      chk("dup_bool", {31'd0, b}, 32'd1);
      chk("dup_value", {24'd0, v}, 32'hA1);
      chk("dup_context", {24'd0, c}, 32'h31);
      req_valid = 1'b1; req_handle = 8'd8; req_rank = 8'd1; isMetadata = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("hold_valid", {31'd0, resp_valid}, 32'd1);
        chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        chk("hold_value", {24'd0, resultValue}, 32'hA1);
        chk("hold_context", {24'd0, resultContext}, 32'h31);
      end
      req_valid = 1'b0;
      finish_resp();
    end

    // clr during the scan kills slot 5 before it is examined.
    write_slot(3'd5, 8'd4, 8'd4, 8'd5, 8'h55, 1'b0);
    run_vec("clr_mid", 8'd4, 8'd4, 1'b1, 2, 9, 1'b0, 8'd4, 8'd4);
    run_vec("clr_after", 8'd4, 8'd4, 1'b1, -1, 9, 1'b0, 8'd4, 8'd4);
    write_slot(3'd5, 8'd4, 8'd4, 8'd5, 8'h55, 1'b1);
    run_vec("wr_with_clr", 8'd4, 8'd4, 1'b1, -1, 9, 1'b0, 8'd4, 8'd4);
    write_slot(3'd5, 8'd4, 8'd4, 8'd5, 8'h55, 1'b0);
    run_vec("rewrite", 8'd4, 8'd4, 1'b1, -1, 7, 1'b1, 8'h55, 8'd5);

    // Asynchronous reset in the middle of a scan.
    write_slot(3'd2, 8'd5, 8'd5, 8'h25, 8'h52, 1'b0);
    req_valid = 1'b1; req_handle = 8'd5; req_rank = 8'd5; isMetadata = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("arst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("arst_bool", {31'd0, resultBool}, 32'd0);
    chk("arst_value", {24'd0, resultValue}, 32'd0);
    chk("arst_context", {24'd0, resultContext}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("arst_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    run_vec("arst_empty", 8'd5, 8'd5, 1'b1, -1, 9, 1'b0, 8'd5, 8'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
